// File: rtl/y_pattern_gen.sv
// y_pattern_gen: raster timing and 8-bit luminance test-pattern source for
// the Y-stream consumers (Sobel and friends). Frames always run to
// completion. Start, stop, pattern and solid value are taken only at frame
// boundaries. Every output is registered one clock after the counter state
// it describes.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | counters parked at 0, outputs idle, waiting for en
// S_RUN  | counters advance every clock; en is re-sampled on the last clock
module y_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned BAR_W    = 80,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [7:0] solid_val,
  output logic [7:0] Y_data,
  output logic       Y_de,
  output logic       Y_hsync,
  output logic       Y_vsync,
  output logic       frame_done
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ONE      = HW'(1);
  localparam logic [VW-1:0] V_ONE      = VW'(1);
  localparam logic [15:0]   BAR_RELOAD = 16'(BAR_W - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_q;
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic [1:0]    mode_q;
  logic [7:0]    solid_q;
  logic [2:0]    bar_q;       // current bar index for mode 1
  logic [15:0]   bar_left_q;  // pixels remaining in the current bar, minus one

  logic [31:0] h_w, v_w;
  logic        h_act_d, v_act_d, de_d, hs_win_d, vs_win_d, h_last_d, v_last_d;
  logic [7:0]  pix_d, data_d;

  // Decode counter position into regions and the pattern for this pixel.
  always_comb begin
    h_w      = 32'(h_cnt_q);
    v_w      = 32'(v_cnt_q);
    h_act_d  = h_w < H_ACTIVE;
    v_act_d  = v_w < V_ACTIVE;
    de_d     = h_act_d & v_act_d;
    hs_win_d = (h_w >= H_ACTIVE + H_FP) && (h_w < H_ACTIVE + H_FP + H_SYNC);
    vs_win_d = (v_w >= V_ACTIVE + V_FP) && (v_w < V_ACTIVE + V_FP + V_SYNC);
    h_last_d = h_w == H_TOTAL - 1;
    v_last_d = v_w == V_TOTAL - 1;
    pix_d    = 8'h00;
    case (mode_q)
      2'd0:    pix_d = h_w[7:0];
      2'd1:    pix_d = {bar_q, 5'b0};
      2'd2:    pix_d = (h_w[CHK_LOG2] ^ v_w[CHK_LOG2]) ? 8'hFF : 8'h00;
      default: pix_d = solid_q;
    endcase
    data_d = de_d ? pix_d : 8'h00;
  end

  // Frame FSM, raster counters, bar tracker and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      mode_q     <= 2'd0;
      solid_q    <= 8'h00;
      bar_q      <= 3'd0;
      bar_left_q <= BAR_RELOAD;
      Y_data     <= 8'h00;
      Y_de       <= 1'b0;
      Y_hsync    <= ~SYNC_POL;
      Y_vsync    <= ~SYNC_POL;
      frame_done <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          h_cnt_q    <= '0;
          v_cnt_q    <= '0;
          bar_q      <= 3'd0;
          bar_left_q <= BAR_RELOAD;
          Y_data     <= 8'h00;
          Y_de       <= 1'b0;
          Y_hsync    <= ~SYNC_POL;
          Y_vsync    <= ~SYNC_POL;
          frame_done <= 1'b0;
          if (en) begin
            mode_q  <= mode;
            solid_q <= solid_val;
            state_q <= S_RUN;
          end
        end

        default: begin
          Y_data     <= data_d;
          Y_de       <= de_d;
          Y_hsync    <= hs_win_d ? SYNC_POL : ~SYNC_POL;
          Y_vsync    <= vs_win_d ? SYNC_POL : ~SYNC_POL;
          frame_done <= h_last_d & v_last_d;

          // Bar index follows h_cnt: restart each line, step every BAR_W active pixels.
          if (h_last_d) begin
            bar_q      <= 3'd0;
            bar_left_q <= BAR_RELOAD;
          end else if (h_act_d) begin
            if (bar_left_q == 16'd0) begin
              bar_q      <= bar_q + 3'd1;
              bar_left_q <= BAR_RELOAD;
            end else begin
              bar_left_q <= bar_left_q - 16'd1;
            end
          end

          if (h_last_d) begin
            h_cnt_q <= '0;
            if (v_last_d) begin
              v_cnt_q <= '0;
              if (en) begin
                mode_q  <= mode;
                solid_q <= solid_val;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              v_cnt_q <= v_cnt_q + V_ONE;
            end
          end else begin
            h_cnt_q <= h_cnt_q + H_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_pattern_gen.sv
// Bench for y_pattern_gen at a small raster (14 x 7 clocks per frame).
// A reference model on the frame's linear pixel index predicts each output
// clock and queues it; a negedge monitor pops and compares.
module tb_y_pattern_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int BW = 2;
  localparam int CL = 1;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [7:0] solid_val;
  logic [7:0] Y_data;
  logic       Y_de, Y_hsync, Y_vsync, frame_done;

  always #5 clk = ~clk;

  y_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .BAR_W(BW), .CHK_LOG2(CL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_val(solid_val),
    .Y_data(Y_data), .Y_de(Y_de), .Y_hsync(Y_hsync), .Y_vsync(Y_vsync),
    .frame_done(frame_done)
  );

  typedef logic [11:0] exp_t;   // {de, data[7:0], hsync, vsync, frame_done}
  localparam exp_t IDLE_OUT = 12'h000;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  bit m_run;
  int m_p, m_mode, m_solid, m_disp;

  function automatic exp_t pixel(int p, int md, int sv);
    int h, v, y;
    bit de, hs, vs, fd;
    h  = p % HT;
    v  = p / HT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF) && (h < HA + HF + HS);
    vs = (v >= VA + VF) && (v < VA + VF + VS);
    case (md)
      0:       y = h % 256;
      1:       y = ((h / BW) % 8) * 32;
      2:       y = (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 255 : 0;
      default: y = sv;
    endcase
    if (!de) y = 0;
    fd = (p == FT - 1);
    return {de, 8'(y), hs, vs, fd};
  endfunction

  function automatic exp_t outs();
    return {Y_de, Y_data, Y_hsync, Y_vsync, frame_done};
  endfunction

  task automatic check(string name, exp_t got, exp_t want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got de=%0b y=%02h hs=%0b vs=%0b fd=%0b, want de=%0b y=%02h hs=%0b vs=%0b fd=%0b",
                  name, $time, got[11], got[10:3], got[2], got[1], got[0],
                  want[11], want[10:3], want[2], want[1], want[0]);
  endtask

  // Reference model: predicts the output presented after each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_run = 0; m_p = 0; m_mode = 0; m_solid = 0; m_disp = -1;
    end else if (!m_run) begin
      exp_q.push_back(IDLE_OUT);
      m_disp = -1;
      if (en) begin
        m_run = 1; m_p = 0; m_mode = int'(mode); m_solid = int'(solid_val);
      end
    end else begin
      exp_q.push_back(pixel(m_p, m_mode, m_solid));
      m_disp = m_p;
      if (m_p == FT - 1) begin
        if (en) begin
          m_p = 0; m_mode = int'(mode); m_solid = int'(solid_val);
        end else begin
          m_run = 0;
        end
      end else begin
        m_p++;
      end
    end
  end

  // Monitor: compare DUT outputs against queued predictions mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pixel", outs(), e);
    end
  end

  initial begin
    bit found;
    rst = 1'b1; en = 1'b0; mode = 2'd0; solid_val = 8'h00;
    repeat (3) @(negedge clk);
    #1 check("reset_idle", outs(), IDLE_OUT);
    @(negedge clk) rst = 1'b0;
    repeat (50) @(negedge clk);

    en = 1'b1; mode = 2'd0;
    repeat (2 * FT) @(negedge clk);
    mode = 2'd1;
    repeat (2 * FT) @(negedge clk);
    mode = 2'd2;
    repeat (2 * FT) @(negedge clk);
    repeat (40) @(negedge clk);
    mode = 2'd3; solid_val = 8'h5A;
    repeat (2 * FT) @(negedge clk);
    repeat (30) @(negedge clk);
    en = 1'b0;
    repeat (FT + 40) @(negedge clk);

    en = 1'b1; mode = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4 * FT && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_disp == 2 * HT + 4) found = 1'b1;
    end
    if (!found) begin
      n_total++;
      $display("FAIL rst_sync_timeout: got no pixel 4 of line 2, want it within %0d clk", 4 * FT);
    end else begin
      check("pre_rst_pixel", outs(), pixel(m_disp, m_mode, m_solid));
      #1 rst = 1'b1;
      #1 check("async_rst", outs(), IDLE_OUT);
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2 * FT) @(negedge clk);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) solid_val = 8'($urandom);
      if ($urandom_range(0, 149) == 0) en = ~en;
    end
    en = 1'b0;
    repeat (FT + 20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/y_pattern_gen.md
Name: y_pattern_gen

Overview:
- Source-side counterpart of the Y-stream consumers in the image_process chain, including the Sobel edge filter.
- Generates raster timing (Y_de, Y_hsync, Y_vsync) and an 8-bit luminance test pattern (Y_data).
- Lets edge-detection and downstream blocks run and be verified without the OV5640 capture path.
- Frame-aligned start/stop; pattern selection is latched per frame.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clk)
- H_SYNC, 96, hsync width (clk)
- H_BP, 48, horizontal back porch (clk)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1, asserted level of Y_hsync/Y_vsync (1 = active-high)
- BAR_W, 80, bar width in pixels for mode 1
- CHK_LOG2, 5, log2 of checker square size for mode 2

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run request; sampled at frame boundaries only
- mode  in  2  pattern select: 0 ramp, 1 bars, 2 checker, 3 solid
- solid_val  in  8  Y value used in mode 3
- Y_data  out  8  pixel luminance; 0 when Y_de low
- Y_de  out  1  active-pixel valid
- Y_hsync  out  1  line sync
- Y_vsync  out  1  frame sync
- frame_done  out  1  one-clk pulse on the last clock of each generated frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counter h_cnt runs 0..H_TOTAL-1. Counter v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Region order (both axes): active, then FP, then SYNC, then BP. Active is h_cnt < H_ACTIVE; hsync spans H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1. Vertical regions are the same, in lines.
- Y_de = h active AND v active. Y_hsync and Y_vsync = SYNC_POL when inside the respective sync window, else ~SYNC_POL.
- Every output is registered. Latency from counter state to outputs is exactly 1 clk, with all outputs aligned.
- State machine:
  - IDLE: counters held at 0. Outputs idle: Y_de=0, Y_data=0, syncs=~SYNC_POL. If en=1, latch mode into mode_q and go to RUN; counting starts on the next clk.
  - RUN: counters advance every clk. At the last clock (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) pulse frame_done. Then: en=1 relatches mode and stays in RUN starting the next frame at 0,0; en=0 goes to IDLE.
  - Deasserting en mid-frame never truncates the frame. The current frame always completes.
- mode and solid_val changes mid-frame are ignored until the next frame. solid_val is latched together with mode.
- Patterns, computed from the counters of the active pixel:
  - mode 0: Y = h_cnt[7:0]; wraps every 256 px.
  - mode 1: bar index b (3 bits) resets to 0 at h_cnt=0 and increments every BAR_W active pixels, wrapping 7 to 0. Y = {b,5'b0}. No divider.
  - mode 2: Y = 8'hFF when h_cnt[CHK_LOG2] XOR v_cnt[CHK_LOG2] is 1, else 8'h00.
  - mode 3: Y = latched solid_val.
- Y_data is forced to 0 whenever Y_de is 0.
- Reset, asynchronous at any time: state IDLE, counters 0, Y_de=0, Y_data=0, Y_hsync=Y_vsync=~SYNC_POL, frame_done=0, mode_q=0, solid_q=0.
- After rst deasserts, wait in IDLE for en.

Test Plan:
- Sim parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), BAR_W=2, CHK_LOG2=1, SYNC_POL=1.
- Reset/idle: rst=1 then 0 with en=0 for 50 clk -> Y_de=0, Y_data=0, Y_hsync=0, Y_vsync=0, frame_done=0 throughout.
- Timing: en=1, mode=0 -> per line 8 de-clk with Y_data 0..7, then 2 idle, 2 hsync-high, 2 idle. vsync high for line 5 only (14 clk). frame_done pulses every 98 clk.
- Bars: mode=1 -> each active line reads 0,0,32,32,64,64,96,96.
- Checker: mode=2 -> line 0 reads 00,00,FF,FF,00,00,FF,FF. Lines 2–3 are inverted.
- Frame-aligned control:
  - mode changed to 3 (solid_val=8'h5A) at mid-frame -> current frame keeps the old pattern; the next frame is all 5A.
  - en=0 at mid-frame -> the frame completes with frame_done, then outputs go idle.
- Async reset mid-line: rst pulse during active pixel 4 of line 2 -> outputs idle immediately without a clock edge. With en=1 after release, the next frame starts at h_cnt=0, v_cnt=0.
